// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: sample/control inputs and match status outputs.
interface seq_detector_param_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               en;
  logic               inp;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               cnt_clr;
  logic               w;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  modport master (
    output en, inp, overlap, pat_load, pat_in, cnt_clr,
    input  w, match_cnt, cnt_sat
  );

  modport slave (
    input  en, inp, overlap, pat_load, pat_in, cnt_clr,
    output w, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a runtime-loadable pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned        PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
  parameter int unsigned        CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);

  localparam int unsigned FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FullFill = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pattern_q;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               w_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               sample;
  logic               hit;

  // Next history/fill and match decision for an enabled sample.
  always_comb begin
    sample = bus.en & ~bus.pat_load;
    hist_d = {hist_q[PAT_LEN-2:0], bus.inp};
    fill_d = (fill_q == FullFill) ? fill_q : fill_q + 1'b1;
    hit    = sample && (fill_d == FullFill) && (hist_d == pattern_q);
  end

  // Pattern, history, fill and the registered match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEFAULT_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      w_q       <= 1'b0;
    end else if (bus.pat_load) begin
      // A new pattern invalidates any partial history.
      pattern_q <= bus.pat_in;
      hist_q    <= '0;
      fill_q    <= '0;
      w_q       <= 1'b0;
    end else if (bus.en) begin
      hist_q <= hist_d;
      w_q    <= hit;
      if (hit && !bus.overlap) begin
        fill_q <= '0;
      end else begin
        fill_q <= fill_d;
      end
    end else begin
      w_q <= 1'b0;
    end
  end

  // Counter next state: a clear coinciding with a hit still counts that hit.
  always_comb begin
    cnt_d = cnt_q;
    if (hit) begin
      if (bus.cnt_clr) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.cnt_clr) begin
      cnt_d = '0;
    end
    sat_d = &cnt_d;
  end

  // Counter and saturation flag registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign bus.w         = w_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param: default 8-bit counter instance
// plus a 2-bit counter instance for saturation behaviour.
module tb_seq_detector_param;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) bus1 ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  seq_detector_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.en = 0; bus1.inp = 0; bus1.overlap = 1; bus1.pat_load = 0;
    bus1.pat_in = 4'b0000; bus1.cnt_clr = 0;
    bus2.en = 0; bus2.inp = 0; bus2.overlap = 1; bus2.pat_load = 0;
    bus2.pat_in = 4'b0000; bus2.cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [3:0] bits;
    logic [3:0] exp_w;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    n_vec++;
    if (bus1.w !== 1'b0 || bus1.match_cnt !== 8'd0 || bus1.cnt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: w=%b cnt=%0d sat=%b, want 0/0/0",
               bus1.w, bus1.match_cnt, bus1.cnt_sat);
    end
    bits  = 4'b1011;
    exp_w = 4'b0001;
    bus1.en = 1;
    for (int i = 3; i >= 0; i--) begin
      bus1.inp = bits[i];
      tick();
      n_vec++;
      if (bus1.w !== exp_w[i]) begin
        n_err++;
        $display("FAIL basic_w[%0d]: w=%b want %b", 3 - i, bus1.w, exp_w[i]);
      end
    end
    bus1.en = 0;
    tick();
    n_vec++;
    if (bus1.w !== 1'b0 || bus1.match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL basic_after: w=%b cnt=%0d, want 0/1", bus1.w, bus1.match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_w;
    bits = 7'b1011011;
    for (int mode = 1; mode >= 0; mode--) begin
      do_reset();
      exp_w = (mode == 1) ? 7'b0001001 : 7'b0001000;
      bus1.overlap = mode[0];
      bus1.en = 1;
      for (int i = 6; i >= 0; i--) begin
        bus1.inp = bits[i];
        tick();
        n_vec++;
        if (bus1.w !== exp_w[i]) begin
          n_err++;
          $display("FAIL overlap%0d_w[%0d]: w=%b want %b", mode, 6 - i, bus1.w, exp_w[i]);
        end
      end
      bus1.en = 0;
      n_vec++;
      if (bus1.match_cnt !== ((mode == 1) ? 8'd2 : 8'd1)) begin
        n_err++;
        $display("FAIL overlap%0d_cnt: cnt=%0d want %0d", mode, bus1.match_cnt,
                 (mode == 1) ? 2 : 1);
      end
    end
  endtask

  task automatic test_pat_load();
    logic [3:0] bits;
    logic [3:0] exp_w;
    do_reset();
    bus1.en = 1;
    bus1.inp = 1; tick();
    bus1.inp = 0; tick();
    bus1.pat_load = 1;
    bus1.pat_in = 4'b0110;
    bus1.inp = 1;
    tick();
    bus1.pat_load = 0;
    n_vec++;
    if (bus1.w !== 1'b0) begin
      n_err++;
      $display("FAIL load_edge_w: w=%b want 0", bus1.w);
    end
    bits  = 4'b0110;
    exp_w = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      bus1.inp = bits[i];
      tick();
      n_vec++;
      if (bus1.w !== exp_w[i]) begin
        n_err++;
        $display("FAIL load_w[%0d]: w=%b want %b", 3 - i, bus1.w, exp_w[i]);
      end
    end
    bus1.en = 0;
    n_vec++;
    if (bus1.match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL load_cnt: cnt=%0d want 1", bus1.match_cnt);
    end
  endtask

  task automatic test_en_gap();
    do_reset();
    bus1.en = 1;
    bus1.inp = 1; tick();
    bus1.inp = 0; tick();
    bus1.en = 0;
    for (int i = 0; i < 3; i++) begin
      bus1.inp = ~bus1.inp;
      tick();
      n_vec++;
      if (bus1.w !== 1'b0) begin
        n_err++;
        $display("FAIL gap_w[%0d]: w=%b want 0", i, bus1.w);
      end
    end
    bus1.en = 1;
    bus1.inp = 1;
    tick();
    n_vec++;
    if (bus1.w !== 1'b0) begin
      n_err++;
      $display("FAIL gap_resume1: w=%b want 0", bus1.w);
    end
    tick();
    n_vec++;
    if (bus1.w !== 1'b1) begin
      n_err++;
      $display("FAIL gap_resume2: w=%b want 1", bus1.w);
    end
    bus1.en = 0;
    tick();
    n_vec++;
    if (bus1.w !== 1'b0 || bus1.match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL gap_after: w=%b cnt=%0d, want 0/1", bus1.w, bus1.match_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [6:0] exp_w;
    logic [13:0] exp_cnt;
    logic [6:0] exp_sat;
    do_reset();
    bus2.pat_load = 1;
    bus2.pat_in = 4'b1111;
    tick();
    bus2.pat_load = 0;
    exp_w   = 7'b0001111;
    exp_cnt = {2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_sat = 7'b0000011;
    bus2.overlap = 1;
    bus2.en = 1;
    bus2.inp = 1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      n_vec++;
      if (bus2.w !== exp_w[i] || bus2.match_cnt !== exp_cnt[2*i +: 2] ||
          bus2.cnt_sat !== exp_sat[i]) begin
        n_err++;
        $display("FAIL sat_step[%0d]: w=%b cnt=%0d sat=%b, want %b/%0d/%b", 6 - i,
                 bus2.w, bus2.match_cnt, bus2.cnt_sat, exp_w[i], exp_cnt[2*i +: 2], exp_sat[i]);
      end
    end
    bus2.cnt_clr = 1;
    tick();
    n_vec++;
    if (bus2.w !== 1'b1 || bus2.match_cnt !== 2'd1 || bus2.cnt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL clr_with_hit: w=%b cnt=%0d sat=%b, want 1/1/0",
               bus2.w, bus2.match_cnt, bus2.cnt_sat);
    end
    bus2.en = 0;
    tick();
    bus2.cnt_clr = 0;
    n_vec++;
    if (bus2.w !== 1'b0 || bus2.match_cnt !== 2'd0 || bus2.cnt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL clr_no_hit: w=%b cnt=%0d sat=%b, want 0/0/0",
               bus2.w, bus2.match_cnt, bus2.cnt_sat);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] bits;
    logic [4:0] exp_w;
    do_reset();
    bus1.pat_load = 1;
    bus1.pat_in = 4'b0110;
    tick();
    bus1.pat_load = 0;
    do_reset();
    bus1.en = 1;
    bus1.inp = 1; tick();
    bus1.inp = 0; tick();
    bus1.inp = 1; tick();
    rst = 1;
    bus1.inp = 1;
    tick();
    rst = 0;
    n_vec++;
    if (bus1.w !== 1'b0 || bus1.match_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_edge: w=%b cnt=%0d, want 0/0", bus1.w, bus1.match_cnt);
    end
    bits  = 5'b11011;
    exp_w = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      bus1.inp = bits[i];
      tick();
      n_vec++;
      if (bus1.w !== exp_w[i]) begin
        n_err++;
        $display("FAIL midrst_w[%0d]: w=%b want %b", 4 - i, bus1.w, exp_w[i]);
      end
    end
    bus1.en = 0;
    n_vec++;
    if (bus1.match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL midrst_cnt: cnt=%0d want 1", bus1.match_cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_overlap();
    test_pat_load();
    test_en_gap();
    test_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector, the next generation of the fixed single-pattern Moore detector. It samples one serial bit per enabled clock and compares the last PAT_LEN bits against a runtime-loadable pattern. It raises a registered one-cycle match pulse and keeps a saturating match counter. Overlapping or non-overlapping detection is selected at runtime. It sits on serial input lines in lab datapaths and feeds status/LED logic.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16).
DEFAULT_PAT, 4'b1011, pattern loaded at reset; bit PAT_LEN-1 is the oldest bit received, bit 0 the newest.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sample enable; inp is consumed only on edges where en=1.
inp  input  1  serial data bit.
overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
pat_load  input  1  load pat_in into the pattern register.
pat_in  input  PAT_LEN  new pattern value.
cnt_clr  input  1  clear the match counter.
w  output  1  registered match pulse.
match_cnt  output  CNT_W  number of matches, saturating.
cnt_sat  output  1  high while match_cnt is all ones.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Priority on each edge: rst > pat_load > en.
- Reset values: pattern=DEFAULT_PAT, hist=0, fill=0, w=0, match_cnt=0, cnt_sat=0. Asserting rst mid-sequence discards all partial history.
- Internal state: hist (PAT_LEN-bit shift register); fill (count of valid bits in hist, 0..PAT_LEN, saturating at PAT_LEN).
- Enabled edge (en=1, no pat_load):
  - hist_n = {hist[PAT_LEN-2:0], inp}
  - fill_n = min(fill+1, PAT_LEN)
  - hit = (fill_n==PAT_LEN) && (hist_n==pattern)
- Registered outputs on that edge:
  - w <= hit, so w is high for exactly the one clock period following the edge that sampled the final pattern bit. This is 1-cycle latency, Moore-style, and w has no combinational path from inp.
  - On hit with overlap=1: hist<=hist_n, fill stays PAT_LEN, so a match can share trailing bits.
  - On hit with overlap=0: hist<=hist_n, fill<=0, so the next match needs PAT_LEN fresh bits.
  - No hit: hist<=hist_n, fill<=fill_n.
- en=0: hist, fill and pattern hold, w<=0, inp is ignored. An en gap does not break a sequence.
- pat_load=1 (with rst=0): pattern<=pat_in, hist<=0, fill<=0, w<=0, and inp on that edge is ignored. match_cnt is unaffected.
- overlap is sampled on each enabled edge. Changing it only affects how fill is updated on subsequent hits.
- Counter:
  - On a hit, match_cnt increments unless it is already all ones; it saturates and never wraps.
  - cnt_sat = (match_cnt == all ones), registered together with match_cnt.
  - cnt_clr without a hit: match_cnt<=0, cnt_sat<=0.
  - cnt_clr together with a hit on the same edge: match_cnt<=1 (clear, then count this match), and w still pulses.
- Patterns of all-zeros and all-ones are legal. With overlap=1 and pattern 1111, a continuous run of ones yields w high on every enabled edge after the fourth.

Test Plan:
1. Apply rst for 2 edges, then release with en=0 -> w=0, match_cnt=0, cnt_sat=0. With en=1 and inp=1,0,1,1 on consecutive edges, w is high only in the cycle after the 4th edge, then match_cnt=1.
2. overlap=1, stream 1,0,1,1,0,1,1 -> w pulses after the 4th and 7th edges, match_cnt=2. Repeat after reset with overlap=0 -> only one pulse, after the 4th edge, match_cnt=1.
3. Stream 1,0, then assert pat_load with pat_in=4'b0110 (inp=1 ignored), then stream 0,1,1,0 -> one w pulse after the last 0, match_cnt=1. The earlier partial bits 1,0 never combine into a match.
4. Stream 1,0, then en=0 for 3 edges with inp toggling, then en=1 with 1,1 -> w pulses after the final 1. w stays 0 throughout the en=0 gap.
5. Use CNT_W=2 with overlap=1 and pattern 1111, then drive 7 ones -> match_cnt reaches 3 and holds at 3, cnt_sat=1. Next, assert cnt_clr on an edge that is also a hit -> match_cnt=1, cnt_sat=0, w=1.
6. Stream 1,0,1, then rst=1 while inp=1 on the next edge, then resume with 1 -> no w pulse. A full 1,0,1,1 afterwards is required before w asserts. The pattern is back to DEFAULT_PAT even if a different pattern was loaded before the reset.
